// File: rtl/rsa_modexp.sv
// Sequential modular exponentiation: result = base^exponent mod modulus, right-to-left
// square-and-multiply over a bit-serial shift-add modmul. Optional macro: RSA_MODEXP_CYCLE_COUNT_EN.
module rsa_modexp #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_compute,
    input  logic [WIDTH-1:0] base,
    input  logic [WIDTH-1:0] exponent,
    input  logic [WIDTH-1:0] modulus,
    output logic [WIDTH-1:0] result,
    output logic             done_compute,
    output logic             busy,
    output logic             error
`ifdef RSA_MODEXP_CYCLE_COUNT_EN
    ,
    output logic [31:0]      cycle_count
`endif
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_REDUCE, S_CHECK, S_MUL_RES, S_MUL_SQR, S_DONE
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] n_q, ex_q, b_q, acc_q, y_q;
    logic [WIDTH:0]   r_q;
    logic [CW-1:0]    cnt_q;

    logic [WIDTH-1:0] x_sel;
    logic [WIDTH:0]   r_dbl, r_dbl_red, r_add, r_add_red, r_next;
    logic             mm_last;

    // One modmul step: r = 2r mod n, then (+x mod n) when the scanned multiplier bit is set.
    always_comb begin
        x_sel = (state == S_MUL_RES) ? acc_q :
                (state == S_MUL_SQR) ? b_q   : WIDTH'(1);
        r_dbl     = {r_q[WIDTH-1:0], 1'b0};
        r_dbl_red = (r_dbl >= {1'b0, n_q}) ? r_dbl - {1'b0, n_q} : r_dbl;
        r_add     = r_dbl_red + {1'b0, x_sel};
        r_add_red = (r_add >= {1'b0, n_q}) ? r_add - {1'b0, n_q} : r_add;
        r_next    = y_q[WIDTH-1] ? r_add_red : r_dbl_red;
        mm_last   = (cnt_q == CW'(WIDTH - 1));
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (start_compute) state_nxt = S_LOAD;
            S_LOAD:    state_nxt = (n_q < WIDTH'(2)) ? S_DONE : S_REDUCE;
            S_REDUCE:  if (mm_last) state_nxt = S_CHECK;
            S_CHECK: begin
                if (ex_q == '0)   state_nxt = S_DONE;
                else if (ex_q[0]) state_nxt = S_MUL_RES;
                else              state_nxt = S_MUL_SQR;
            end
            S_MUL_RES: if (mm_last) state_nxt = S_MUL_SQR;
            S_MUL_SQR: if (mm_last) state_nxt = S_CHECK;
            S_DONE:    if (!start_compute) state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    assign busy         = (state != S_IDLE) && (state != S_DONE);
    assign done_compute = (state == S_DONE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            n_q    <= '0;
            ex_q   <= '0;
            b_q    <= '0;
            acc_q  <= '0;
            y_q    <= '0;
            r_q    <= '0;
            cnt_q  <= '0;
            result <= '0;
            error  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (start_compute) begin
                    n_q   <= modulus;
                    ex_q  <= exponent;
                    y_q   <= base;
                    r_q   <= '0;
                    cnt_q <= '0;
                end
                S_LOAD: begin
                    error  <= (n_q < WIDTH'(2));
                    result <= '0;
                    acc_q  <= WIDTH'(1);
                end
                S_CHECK: begin
                    if (ex_q == '0) result <= acc_q;
                    y_q   <= b_q;
                    r_q   <= '0;
                    cnt_q <= '0;
                end
                S_REDUCE, S_MUL_RES, S_MUL_SQR: begin
                    r_q   <= r_next;
                    y_q   <= y_q << 1;
                    cnt_q <= cnt_q + CW'(1);
                    if (mm_last) begin
                        r_q   <= '0;
                        cnt_q <= '0;
                        case (state)
                            S_REDUCE:  b_q <= r_next[WIDTH-1:0];
                            S_MUL_RES: begin
                                acc_q <= r_next[WIDTH-1:0];
                                y_q   <= b_q;
                            end
                            default: begin
                                b_q  <= r_next[WIDTH-1:0];
                                ex_q <= ex_q >> 1;
                            end
                        endcase
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef RSA_MODEXP_CYCLE_COUNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                           cycle_count <= '0;
        else if (state == S_LOAD)            cycle_count <= '0;
        else if (busy && (cycle_count != '1)) cycle_count <= cycle_count + 32'd1;
    end
`endif

endmodule

// File: tb/tb_rsa_modexp.sv
// Directed self-checking bench for rsa_modexp at WIDTH=64 with hand-computed expected values.
module tb_rsa_modexp;

    localparam int WIDTH = 64;
    localparam int BOUND = 20000;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             start_compute = 1'b0;
    logic [WIDTH-1:0] base = '0;
    logic [WIDTH-1:0] exponent = '0;
    logic [WIDTH-1:0] modulus = '0;
    logic [WIDTH-1:0] result;
    logic             done_compute;
    logic             busy;
    logic             error;
`ifdef RSA_MODEXP_CYCLE_COUNT_EN
    logic [31:0]      cycle_count;
`endif

    int errors = 0;
    int checks = 0;

    rsa_modexp #(.WIDTH(WIDTH)) dut (
        .clk          (clk),
        .reset        (reset),
        .start_compute(start_compute),
        .base         (base),
        .exponent     (exponent),
        .modulus      (modulus),
        .result       (result),
        .done_compute (done_compute),
        .busy         (busy),
        .error        (error)
`ifdef RSA_MODEXP_CYCLE_COUNT_EN
        ,
        .cycle_count  (cycle_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic start_op(input logic [WIDTH-1:0] b, input logic [WIDTH-1:0] e,
                            input logic [WIDTH-1:0] m);
        @(negedge clk);
        base = b;
        exponent = e;
        modulus = m;
        start_compute = 1'b1;
    endtask

    // edges counts posedges from the one that samples start up to the first with done high.
    task automatic wait_done(input string name, output int edges);
        edges = 0;
        while (1) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
            if (done_compute) break;
            if (edges >= BOUND) break;
        end
        checks++;
        if (done_compute !== 1'b1) begin
            errors++;
            $display("FAIL %s_timeout: done_compute=%b after %0d cycles, required 1", name, done_compute, edges);
        end
    endtask

    task automatic release_op(input string name);
        @(negedge clk);
        start_compute = 1'b0;
        @(negedge clk);
        checks++;
        if (done_compute !== 1'b0) begin
            errors++;
            $display("FAIL %s_release: done_compute=%b, required 0", name, done_compute);
        end
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if ({result, done_compute, busy, error} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: result=%0d done=%b busy=%b error=%b, required all 0",
                     result, done_compute, busy, error);
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if ({done_compute, busy} !== 2'b00) begin
            errors++;
            $display("FAIL reset_idle: done=%b busy=%b, required 0 0", done_compute, busy);
        end
    endtask

    task automatic test_basic();
        int edges;
        start_op(64'd4, 64'd13, 64'd497);
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL basic_busy: busy=%b, required 1", busy);
        end
        base = 64'd7;
        exponent = 64'd2;
        modulus = 64'd11;
        wait_done("basic", edges);
        checks++;
        if (result !== 64'd445 || error !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_result: result=%0d error=%b busy=%b, required 445 0 0", result, error, busy);
        end
        repeat (10) @(negedge clk);
        checks++;
        if (done_compute !== 1'b1 || result !== 64'd445 || busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_hold: done=%b result=%0d busy=%b, required 1 445 0",
                     done_compute, result, busy);
        end
        release_op("basic");
    endtask

    task automatic test_rsa_roundtrip();
        int edges;
        start_op(64'd65, 64'd17, 64'd3233);
        wait_done("encrypt", edges);
        checks++;
        if (result !== 64'd2790) begin
            errors++;
            $display("FAIL encrypt_result: result=%0d, required 2790", result);
        end
        release_op("encrypt");
        start_op(64'd2790, 64'd2753, 64'd3233);
        wait_done("decrypt", edges);
        checks++;
        if (result !== 64'd65 || error !== 1'b0) begin
            errors++;
            $display("FAIL decrypt_result: result=%0d error=%b, required 65 0", result, error);
        end
        release_op("decrypt");
    endtask

    task automatic test_exp_zero();
        int edges;
        start_op(64'd12345, 64'd0, 64'd3233);
        wait_done("exp0", edges);
        checks++;
        if (result !== 64'd1) begin
            errors++;
            $display("FAIL exp0_result: result=%0d, required 1", result);
        end
        checks++;
        if (edges - 1 !== 2 + WIDTH) begin
            errors++;
            $display("FAIL exp0_latency: latency=%0d cycles, required %0d", edges - 1, 2 + WIDTH);
        end
        release_op("exp0");
    endtask

    task automatic test_base_ge_mod();
        int edges;
        start_op(64'd3300, 64'd1, 64'd3233);
        wait_done("bigbase", edges);
        checks++;
        if (result !== 64'd67) begin
            errors++;
            $display("FAIL bigbase_result: result=%0d, required 67", result);
        end
        release_op("bigbase");
    endtask

    task automatic test_error();
        int edges;
        logic [WIDTH-1:0] mods [2];
        mods[0] = 64'd1;
        mods[1] = 64'd0;
        for (int i = 0; i < 2; i++) begin
            start_op(64'd5, 64'd3, mods[i]);
            wait_done("modsmall", edges);
            checks++;
            if (error !== 1'b1 || result !== '0 || edges !== 2) begin
                errors++;
                $display("FAIL modsmall_%0d: error=%b result=%0d cycles=%0d, required 1 0 2",
                         mods[i], error, result, edges);
            end
            release_op("modsmall");
        end
        // A successful run after an error must clear the error flag.
        start_op(64'd2, 64'd3, 64'd7);
        wait_done("errclear", edges);
        checks++;
        if (error !== 1'b0 || result !== 64'd1) begin
            errors++;
            $display("FAIL errclear: error=%b result=%0d, required 0 1", error, result);
        end
        release_op("errclear");
    endtask

    task automatic test_start_drop();
        int edges;
        start_op(64'd65, 64'd17, 64'd3233);
        repeat (5) @(negedge clk);
        start_compute = 1'b0;
        wait_done("drop", edges);
        checks++;
        if (result !== 64'd2790) begin
            errors++;
            $display("FAIL drop_result: result=%0d, required 2790", result);
        end
        @(negedge clk);
        checks++;
        if (done_compute !== 1'b0) begin
            errors++;
            $display("FAIL drop_idle: done=%b, required 0", done_compute);
        end
    endtask

    task automatic test_reset_mid();
        int edges;
        start_op(64'd65, 64'd17, 64'd3233);
        repeat (150) @(negedge clk);
        start_compute = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if ({result, done_compute, busy, error} !== '0) begin
            errors++;
            $display("FAIL midreset_outputs: result=%0d done=%b busy=%b error=%b, required all 0",
                     result, done_compute, busy, error);
        end
        @(negedge clk);
        reset = 1'b0;
        start_op(64'd65, 64'd17, 64'd3233);
        wait_done("midreset", edges);
        checks++;
        if (result !== 64'd2790 || error !== 1'b0) begin
            errors++;
            $display("FAIL midreset_rerun: result=%0d error=%b, required 2790 0", result, error);
        end
        release_op("midreset");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_rsa_roundtrip();
        test_exp_zero();
        test_base_ge_mod();
        test_error();
        test_start_drop();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
